// File: rtl/fir_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_pkg
// Description : Shared constants, state encoding and the saturation helper
//               for the FIR decimating output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_decim_pkg;

    // Width of the incoming FIR sample stream
    localparam int FIR_W = 16;

    // Output-stage state machine encoding
    typedef logic [0:0] state_t;
    localparam state_t FILL = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Clamp a 17-bit signed value into the signed range of an out_w-bit word.
    // The result stays 17 bits wide; the caller keeps the low out_w bits.
    function automatic logic signed [FIR_W:0] saturate(
        input logic signed [FIR_W:0] x,
        input int                    out_w
    );
        logic signed [FIR_W:0] hi;
        logic signed [FIR_W:0] lo;
        hi = (FIR_W+1)'((1 << (out_w - 1)) - 1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_decim_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_fifo
// Description : Synchronous FIFO with log2(DEPTH)+1 bit wrapping pointers.
//               A write while full is dropped unless a read happens in the
//               same cycle. No read-through bypass: a write into an empty
//               FIFO becomes visible the following cycle.
// Ports       : clk      - rising-edge clock
//               reset    - synchronous active-low reset (empties the FIFO)
//               wr_en    - write request
//               wr_data  - write data
//               full     - FIFO holds DEPTH entries
//               rd_en    - read request (pops the head when not empty)
//               rd_data  - head entry, zero when empty
//               empty    - FIFO holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_fifo
    import fir_decim_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_rd_go;
    logic w_wr_go;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A read in the same cycle frees a slot, so a write to a full FIFO succeeds
    assign w_rd_go = rd_en && !empty;
    assign w_wr_go = wr_en && (!full || w_rd_go);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_go) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/fir_decim_out.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_out
// Description : Output stage of the 13-tap FIR. Drops the first SKIP valid
//               samples after reset, keeps 1 of every DECIM thereafter,
//               scales by an arithmetic right shift of SHIFT, saturates to
//               OUT_W signed bits, and queues the result in a FIFO behind a
//               valid/ready interface.
//               Optional macro FIR_DECIM_ROUND_EN: round half-up before the
//               shift instead of truncating (floor).
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-low reset
//               din        - FIR output sample, two's complement
//               din_valid  - din carries a new sample
//               dout       - output sample, signed OUT_W bits
//               dout_valid - dout carries a sample
//               dout_ready - consumer accepts dout
//               ovf        - sticky: kept sample dropped on a full FIFO
//               sat        - sticky: kept sample was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_out
    import fir_decim_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int SKIP  = 12,
    parameter int SHIFT = 4,
    parameter int OUT_W = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FIR_W-1:0] din,
    input  logic             din_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
    output logic             sat
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SK_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [SK_W-1:0] SK_LAST = SK_W'((SKIP > 0) ? (SKIP - 1) : 0);

    state_t           r_state;
    logic [SK_W-1:0]  r_skip_cnt;
    logic [PH_W-1:0]  r_phase;
    logic             r_s_valid;
    logic [OUT_W-1:0] r_s_data;
    logic             r_ovf;
    logic             r_sat;

    logic                    w_run;
    logic                    w_keep;
    logic signed [FIR_W:0]   w_ext;
    logic signed [FIR_W:0]   w_pre;
    logic signed [FIR_W:0]   w_shift;
    logic signed [FIR_W:0]   w_clamp;
    logic                    w_clamped;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_rd;
    logic [OUT_W-1:0]        w_rd_data;

    // ------------------------------------------------------------------
    // Sample selection. With SKIP=0 the FILL cycle right after reset
    // already behaves as RUN, so no sample is lost.
    // ------------------------------------------------------------------
    assign w_run  = (r_state == RUN) || (SKIP == 0);
    assign w_keep = din_valid && w_run && (r_phase == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= FILL;
            r_skip_cnt <= '0;
            r_phase    <= '0;
        end else begin
            if (r_state == FILL) begin
                if (SKIP == 0) begin
                    r_state <= RUN;
                end else if (din_valid) begin
                    r_skip_cnt <= r_skip_cnt + 1'b1;
                    if (r_skip_cnt == SK_LAST) begin
                        r_state <= RUN;
                    end
                end
            end
            if (w_run && din_valid) begin
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling in 17 bits so the rounding offset cannot overflow
    // ------------------------------------------------------------------
    assign w_ext = $signed({din[FIR_W-1], din});

`ifdef FIR_DECIM_ROUND_EN
    generate
        if (SHIFT > 0) begin : g_round
            assign w_pre = w_ext + (FIR_W+1)'(1 << (SHIFT - 1));
        end else begin : g_no_round
            assign w_pre = w_ext;
        end
    endgenerate
`else
    assign w_pre = w_ext;
`endif

    assign w_shift   = w_pre >>> SHIFT;
    assign w_clamp   = saturate(w_shift, OUT_W);
    assign w_clamped = (w_clamp != w_shift);

    // ------------------------------------------------------------------
    // Scale/saturate register stage and sticky flags
    // ------------------------------------------------------------------
    assign w_rd = !w_empty && dout_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_sat     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_s_valid <= w_keep;
            if (w_keep) begin
                r_s_data <= w_clamp[OUT_W-1:0];
                if (w_clamped) begin
                    r_sat <= 1'b1;
                end
            end
            // Dropped only when full and no pop frees a slot this cycle
            if (r_s_valid && w_full && !w_rd) begin
                r_ovf <= 1'b1;
            end
        end
    end

    fir_decim_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (r_s_valid),
        .wr_data (r_s_data),
        .full    (w_full),
        .rd_en   (w_rd),
        .rd_data (w_rd_data),
        .empty   (w_empty)
    );

    assign dout       = w_rd_data;
    assign dout_valid = !w_empty;
    assign ovf        = r_ovf;
    assign sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_out
// Description : Scoreboard bench for fir_decim_out. A reference model derives
//               each expected output from the sample count since reset and
//               plain integer arithmetic; a monitor compares DUT output
//               against the queue of expected samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_out;

    localparam int DECIM = 4;
    localparam int SKIP  = 12;
    localparam int SHIFT = 4;
    localparam int OUT_W = 12;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [15:0]      din = '0;
    logic             din_valid = 1'b0;
    logic             dout_ready = 1'b0;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             ovf;
    logic             sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_decim_out #(
        .DECIM (DECIM),
        .SKIP  (SKIP),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf        (ovf),
        .sat        (sat)
    );

    // ---------------- reference model state ----------------
    int sb[$];          // expected output samples, oldest first
    int mocc = 0;       // modelled FIFO occupancy
    int n_seen = 0;     // valid samples since reset
    bit stg_v = 1'b0;   // a kept sample is in flight to the FIFO
    int stg_val = 0;
    bit exp_ovf = 1'b0;
    bit exp_sat = 1'b0;
    bit armed = 1'b0;

    function automatic int ref_scale(input logic [15:0] d, output bit clamped);
        int v;
        int hi;
        int lo;
        v = int'($signed(d));
`ifdef FIR_DECIM_ROUND_EN
        if (SHIFT > 0) v = v + (1 << (SHIFT - 1));
`endif
        v  = v >>> SHIFT;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        clamped = 1'b0;
        if (v > hi) begin
            v = hi;
            clamped = 1'b1;
        end else if (v < lo) begin
            v = lo;
            clamped = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: one kept sample reaches the FIFO one edge after it is sampled
    always @(posedge clk) begin
        bit rd;
        bit clamped;
        if (!reset) begin
            sb.delete();
            mocc    = 0;
            n_seen  = 0;
            stg_v   = 1'b0;
            exp_ovf = 1'b0;
            exp_sat = 1'b0;
        end else begin
            rd = (mocc > 0) && dout_ready;
            if (stg_v) begin
                if (mocc < DEPTH || rd) begin
                    sb.push_back(stg_val);
                    mocc++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (rd) mocc--;
            stg_v = 1'b0;
            if (din_valid) begin
                if (n_seen >= SKIP && ((n_seen - SKIP) % DECIM) == 0) begin
                    stg_val = ref_scale(din, clamped);
                    stg_v   = 1'b1;
                    if (clamped) exp_sat = 1'b1;
                end
                n_seen++;
            end
        end
    end

    // Monitor: sampled between edges, inputs already settled for next edge
    always @(negedge clk) begin
        #1;
        if (armed) begin
            chk("dout_valid", dout_valid, mocc > 0);
            if (dout_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got dout=%0d expected no output", $signed(dout));
                end else begin
                    chk("dout", $signed(dout), sb[0]);
                    if (dout_ready) void'(sb.pop_front());
                end
            end
            chk("ovf", ovf, exp_ovf);
            chk("sat", sat, exp_sat);
        end
    end

    task automatic cyc(input bit v, input logic [15:0] d, input bit rdy);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        dout_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] dir [4];
        int cnt;
        dir[0] = 16'h7FFF;
        dir[1] = 16'h8000;
        dir[2] = 16'hFFF8;
        dir[3] = 16'h0008;

        // Reset state
        @(negedge clk);
        reset = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat", sat, 0);
        armed = 1'b1;
        reset = 1'b1;

        // Fill discard then steady 0x0100 stream
        repeat (52) cyc(1'b1, 16'h0100, 1'b1);

        // Range boundaries and rounding-sensitive values, each lands on phase 0
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc(1'b1, dir[i], 1'b1);
        end

        // Random traffic with random back-pressure
        repeat (200) cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
        repeat (20) cyc(1'b0, 16'h0, 1'b1);
        chk("drain_sb", sb.size(), 0);
        chk("drain_valid", dout_valid, 0);

        // Reset asserted for one cycle mid-stream
        repeat (30) cyc(1'b1, 16'($urandom), 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        din_valid = 1'b0;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_sat", sat, 0);

        // Latency: 13th sample after reset appears two cycles later
        repeat (12) cyc(1'b1, 16'h0100, 1'b1);
        cyc(1'b1, 16'h0100, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        chk("lat1_valid", dout_valid, 0);
        cyc(1'b0, 16'h0, 1'b1);
        chk("lat2_valid", dout_valid, 1);
        chk("lat2_dout", dout, 16);
        repeat (5) cyc(1'b0, 16'h0, 1'b1);

        // Full FIFO with a simultaneous read and write
        do_reset();
        repeat (12) cyc(1'b1, 16'($urandom), 1'b0);
        repeat (32) cyc(1'b1, 16'($urandom), 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 1'b0);
        chk("full_valid", dout_valid, 1);
        chk("full_ovf", ovf, 0);
        cyc(1'b1, 16'($urandom), 1'b0);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        chk("full_rw_ovf", ovf, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (dout_valid === 1'b1) cnt++;
            cyc(1'b0, 16'h0, 1'b1);
        end
        chk("full_rw_occ", cnt, 8);

        // Nine kept samples into an 8-deep FIFO with no reads
        repeat (36) cyc(1'b1, 16'($urandom), 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 1'b0);
        chk("ovf_set", ovf, 1);
        cnt = 0;
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (dout_valid === 1'b1) cnt++;
            cyc(1'b0, 16'h0, 1'b1);
        end
        chk("ovf_occ", cnt, 8);
        chk("ovf_end_valid", dout_valid, 0);
        chk("ovf_sticky", ovf, 1);

        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
